video_rgb_downsampler: RTL

Converts an Avalon-ST RGB101010 pixel stream (30-bit) to RGB565 (16-bit) for the 16-bit pixel buffer and DMA path, with optional 4x4 ordered (Bayer) dithering. It is the narrowing counterpart of the existing 8-to-10-bit RGB upsampler and uses the same one-register streaming pipeline and status slave. Pixel column and row counters track position in the frame to index the dither matrix.

---
 rtl/video_rgb_downsampler_if.sv | 53 +++++
 rtl/video_rgb_downsampler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/video_rgb_downsampler_if.sv
// rtl/video_rgb_downsampler_if.sv - stream and status bus bundle for the RGB101010 to RGB565 downsampler
//
// Purpose: groups the Avalon-ST input stream, the Avalon-ST output stream and
// the read-only status slave into one bundle.
// Modports:
//   slave  - the downsampler's view (consumes stream_in_*, produces stream_out_*,
//            answers slave_read with slave_readdata)
//   master - the surrounding system's view (the mirror image)
interface video_rgb_downsampler_if #(
  parameter int IDW = 29,
  parameter int ODW = 15,
  parameter int IEW = 1,
  parameter int OEW = 0
);
  logic [IDW:0] stream_in_data;
  logic         stream_in_startofpacket;
  logic         stream_in_endofpacket;
  logic [IEW:0] stream_in_empty;
  logic         stream_in_valid;
  logic         stream_in_ready;

  logic         slave_read;
  logic [31:0]  slave_readdata;

  logic         stream_out_ready;
  logic [ODW:0] stream_out_data;
  logic         stream_out_startofpacket;
  logic         stream_out_endofpacket;
  logic [OEW:0] stream_out_empty;
  logic         stream_out_valid;

  modport slave (
    input  stream_in_data, stream_in_startofpacket, stream_in_endofpacket,
    input  stream_in_empty, stream_in_valid,
    output stream_in_ready,
    input  slave_read,
    output slave_readdata,
    input  stream_out_ready,
    output stream_out_data, stream_out_startofpacket, stream_out_endofpacket,
    output stream_out_empty, stream_out_valid
  );

  modport master (
    output stream_in_data, stream_in_startofpacket, stream_in_endofpacket,
    output stream_in_empty, stream_in_valid,
    input  stream_in_ready,
    output slave_read,
    input  slave_readdata,
    output stream_out_ready,
    input  stream_out_data, stream_out_startofpacket, stream_out_endofpacket,
    input  stream_out_empty, stream_out_valid
  );
endinterface

// File: rtl/video_rgb_downsampler.sv
// rtl/video_rgb_downsampler.sv - RGB101010 to RGB565 stream converter with 4x4 ordered dither
//
// Purpose: narrows a 30-bit RGB101010 pixel stream to 16-bit RGB565 through a
// single output register stage, optionally adding a Bayer threshold before
// truncation. Column/row counters locate each pixel inside the dither tile.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - synchronous, active-high
//   bus   - video_rgb_downsampler_if.slave: stream_in_*, stream_out_*,
//           slave_read / slave_readdata status word
module video_rgb_downsampler #(
  parameter int          IDW        = 29,
  parameter int          ODW        = 15,
  parameter int          IEW        = 1,
  parameter int          OEW        = 0,
  parameter int          WIDTH      = 640,
  parameter int          DITHER     = 1,
  parameter logic [15:0] STATUS_IN  = 16'h0019,
  parameter logic [15:0] STATUS_OUT = 16'h0011
) (
  input logic clk,
  input logic reset,
  video_rgb_downsampler_if.slave bus
);

  // Column counter is at least 2 bits so x[1:0] always exists for the tile index.
  localparam int XW = (WIDTH > 4) ? $clog2(WIDTH) : 2;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);

  // 4x4 Bayer matrix, indexed by {y[1:0], x[1:0]}.
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  logic [ODW:0]  data_q;
  logic          sop_q;
  logic          eop_q;
  logic [OEW:0]  empty_q;
  logic          valid_q;
  logic [31:0]   readdata_q;
  logic [XW-1:0] x_q, x_d;
  logic [1:0]    y_q, y_d;

  logic          in_ready;
  logic          xfer;
  logic [XW-1:0] x_use;
  logic [1:0]    y_use;
  logic [3:0]    d;
  logic [10:0]   r_sum, g_sum, b_sum;
  logic [4:0]    r5, b5;
  logic [5:0]    g6;
  logic [ODW:0]  conv;

  // Upper empty bits have no meaning on the narrower output.
  logic unused_empty;
  assign unused_empty = ^bus.stream_in_empty;

  assign in_ready = bus.stream_out_ready | ~valid_q;
  assign xfer     = bus.stream_in_valid & in_ready;

  always_comb begin
    // A SOP always restarts the dither tile, wherever the counters were.
    x_use = bus.stream_in_startofpacket ? '0 : x_q;
    y_use = bus.stream_in_startofpacket ? '0 : y_q;
    d     = (DITHER != 0) ? BAYER[{y_use, x_use[1:0]}] : 4'd0;

    // Red/blue drop 5 bits, so the 4-bit threshold is scaled by 2; green drops 4.
    r_sum = {1'b0, bus.stream_in_data[29:20]} + {6'b0, d, 1'b0};
    g_sum = {1'b0, bus.stream_in_data[19:10]} + {7'b0, d};
    b_sum = {1'b0, bus.stream_in_data[9:0]}   + {6'b0, d, 1'b0};
    r5    = r_sum[10] ? 5'h1F : r_sum[9:5];
    g6    = g_sum[10] ? 6'h3F : g_sum[9:4];
    b5    = b_sum[10] ? 5'h1F : b_sum[9:5];
    conv  = {r5, g6, b5};

    x_d = x_q;
    y_d = y_q;
    if (xfer) begin
      if (x_use == X_LAST) begin
        x_d = '0;
        y_d = y_use + 2'd1;
      end else begin
        x_d = x_use + XW'(1);
        y_d = y_use;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      empty_q    <= '0;
      valid_q    <= 1'b0;
      readdata_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      if (in_ready) begin
        data_q  <= conv;
        sop_q   <= bus.stream_in_startofpacket;
        eop_q   <= bus.stream_in_endofpacket;
        empty_q <= bus.stream_in_empty[OEW:0];
        valid_q <= bus.stream_in_valid;
      end
      if (bus.slave_read) begin
        readdata_q <= {STATUS_OUT, STATUS_IN};
      end
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign bus.stream_in_ready          = in_ready;
  assign bus.stream_out_data          = data_q;
  assign bus.stream_out_startofpacket = sop_q;
  assign bus.stream_out_endofpacket   = eop_q;
  assign bus.stream_out_empty         = empty_q;
  assign bus.stream_out_valid         = valid_q;
  assign bus.slave_readdata           = readdata_q;

endmodule
